pqueue_heap: RTL and testbench

//  Parametrised min-priority queue holding (key, payload) pairs in a binary min-heap array.

---
 rtl/pqueue_heap.sv | 162 ++++++++++++++++
 tb/tb_pqueue_heap.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pqueue_heap.sv
// Min-priority queue of (key, payload) pairs in a binary heap array.
// Heap repair walks one level per cycle behind a valid/ready command port.
module pqueue_heap #(
   parameter int N      = 16,
   parameter int KEY_W  = 8,
   parameter int DATA_W = 8,
   localparam int CW    = $clog2(N + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        cmd,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [KEY_W-1:0]  in_key,
   input  logic [DATA_W-1:0] in_data,
   output logic [KEY_W-1:0]  top_key,
   output logic [DATA_W-1:0] top_data,
   output logic              top_valid,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty,
   output logic              err
);

   localparam int IW = (N > 2) ? $clog2(N) : 1;
   localparam int XW = IW + 2;

   typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              err_q, err_d;
   logic              rdy_q, rdy_d;
   logic [KEY_W-1:0]  key_q [N];
   logic [KEY_W-1:0]  key_d [N];
   logic [DATA_W-1:0] data_q [N];
   logic [DATA_W-1:0] data_d [N];

   logic [IW-1:0]     par_i, l_i, r_i, c_i, lst_i, new_i;
   logic [XW-1:0]     lc, rc;
   logic              lv, rv;

   always_comb begin
      par_i = (idx_q - IW'(1)) >> 1;
      lc    = XW'({idx_q, 1'b1});
      rc    = lc + XW'(1);
      lv    = lc < XW'(cnt_q);
      rv    = rc < XW'(cnt_q);
      l_i   = lc[IW-1:0];
      r_i   = rc[IW-1:0];
      c_i   = (rv && key_q[r_i] < key_q[l_i]) ? r_i : l_i;
      lst_i = IW'(cnt_q - CW'(1));
      new_i = IW'(cnt_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      key_d   = key_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               unique case (cmd)
                  2'd1: begin
                     if (cnt_q == CW'(N)) begin
                        err_d = 1'b1;
                     end else begin
                        key_d[new_i]  = in_key;
                        data_d[new_i] = in_data;
                        cnt_d         = cnt_q + CW'(1);
                        idx_d         = new_i;
                        if (cnt_q != '0) state_d = SIFT_UP;
                     end
                  end
                  2'd2: begin
                     if (cnt_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        key_d[0]  = key_q[lst_i];
                        data_d[0] = data_q[lst_i];
                        cnt_d     = cnt_q - CW'(1);
                        idx_d     = '0;
                        if (cnt_q > CW'(2)) state_d = SIFT_DOWN;
                     end
                  end
                  2'd3: begin
                     if (cnt_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        key_d[0]  = in_key;
                        data_d[0] = in_data;
                        idx_d     = '0;
                        if (cnt_q > CW'(1)) state_d = SIFT_DOWN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         SIFT_UP: begin
            if (idx_q == '0 || key_q[idx_q] >= key_q[par_i]) begin
               state_d = IDLE;
            end else begin
               key_d[idx_q]  = key_q[par_i];
               data_d[idx_q] = data_q[par_i];
               key_d[par_i]  = key_q[idx_q];
               data_d[par_i] = data_q[idx_q];
               idx_d         = par_i;
            end
         end
         SIFT_DOWN: begin
            if (!lv || key_q[idx_q] <= key_q[c_i]) begin
               state_d = IDLE;
            end else begin
               key_d[idx_q]  = key_q[c_i];
               data_d[idx_q] = data_q[c_i];
               key_d[c_i]    = key_q[idx_q];
               data_d[c_i]   = data_q[idx_q];
               idx_d         = c_i;
            end
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   // Heap storage is not reset; only slots below count are meaningful.
   always_ff @(posedge clock) begin
      key_q  <= key_d;
      data_q <= data_d;
   end

   assign cmd_ready = rdy_q;
   assign count     = cnt_q;
   assign full      = (cnt_q == CW'(N));
   assign empty     = (cnt_q == '0);
   assign err       = err_q;
   assign top_valid = rdy_q && !empty;
   assign top_key   = top_valid ? key_q[0]  : '0;
   assign top_data  = top_valid ? data_q[0] : '0;

endmodule

// File: tb/tb_pqueue_heap.sv
// Scoreboard bench for pqueue_heap: directed scenarios plus a random
// command stream checked against a multiset reference model.
module tb_pqueue_heap;

   localparam int N = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] cmd = '0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] in_key = '0;
   logic [7:0] in_data = '0;
   logic [7:0] top_key;
   logic [7:0] top_data;
   logic       top_valid;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       err;

   pqueue_heap #(.N(N), .KEY_W(8), .DATA_W(8)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .in_key(in_key), .in_data(in_data),
      .top_key(top_key), .top_data(top_data), .top_valid(top_valid),
      .count(count), .full(full), .empty(empty), .err(err)
   );

   always #5 clock = ~clock;

   typedef struct packed {logic [7:0] k; logic [7:0] d;} ent_t;

   ent_t mdl[$];
   ent_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [1:0] NOOP = 2'd0, PUSH = 2'd1, POP = 2'd2, REPL = 2'd3;

   // Removes and returns one minimum-key entry from the model.
   function automatic ent_t model_take_min();
      int   m = 0;
      ent_t e;
      for (int i = 1; i < mdl.size(); i++)
         if (mdl[i].k < mdl[m].k) m = i;
      e = mdl[m];
      mdl.delete(m);
      return e;
   endfunction

   // Issues one command, holding cmd_valid until cmd_ready returns.
   task automatic do_cmd(input logic [1:0] c, input logic [7:0] k,
                         input logic [7:0] d, output logic [7:0] pk,
                         output logic [7:0] pd, output logic pv,
                         output logic es, output int busy);
      int g = 0;
      cmd = c; in_key = k; in_data = d; cmd_valid = 1'b1;
      while (!cmd_ready && g < 50) begin
         @(negedge clock); g++;
      end
      if (g >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout cmd=%0d", c);
      end
      pk = top_key; pd = top_data; pv = top_valid;
      @(negedge clock);
      es = err;
      busy = 0;
      while (!cmd_ready && busy < 50) begin
         busy++; @(negedge clock);
      end
      cmd_valid = 1'b0;
      if (busy >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL busy_timeout cmd=%0d", c);
      end
   endtask

   task automatic check_heap(string nm);
      int bad = 0;
      for (int i = 1; i < int'(count); i++)
         if (dut.key_q[(i - 1) / 2] > dut.key_q[i]) bad++;
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL %s heap_order got %0d violations want 0", nm, bad);
      end
   endtask

   task automatic test_reset();
      logic [7:0] pk, pd; logic pv, es; int b;
      n_cmp++;
      if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
          cmd_ready !== 1'b1 || err !== 1'b0 || top_valid !== 1'b0 ||
          top_key !== 8'd0 || top_data !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_init got cnt=%0d emp=%b rdy=%b err=%b tv=%b",
                  count, empty, cmd_ready, err, top_valid);
      end
      for (int i = 1; i <= 7; i++)
         do_cmd(PUSH, 8'(i), 8'(i), pk, pd, pv, es, b);
      cmd = POP; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy got rdy=%b want 0", cmd_ready);
      end
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
          cmd_ready !== 1'b1 || err !== 1'b0 || top_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid got cnt=%0d emp=%b rdy=%b err=%b tv=%b",
                  count, empty, cmd_ready, err, top_valid);
      end
      mdl.delete();
   endtask

   task automatic test_basic();
      logic [7:0] pk, pd; logic pv, es; int b;
      logic [7:0] ks [5];
      ent_t e;
      ks = '{8'd9, 8'd4, 8'd7, 8'd1, 8'd8};
      foreach (ks[i]) begin
         do_cmd(PUSH, ks[i], ks[i] + 8'd100, pk, pd, pv, es, b);
         mdl.push_back('{k: ks[i], d: ks[i] + 8'd100});
      end
      n_cmp++;
      if (top_key !== 8'd1 || top_data !== 8'd101 || top_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_top got %0d/%0d want 1/101", top_key, top_data);
      end
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(model_take_min());
         do_cmd(POP, 8'd0, 8'd0, pk, pd, pv, es, b);
         e = exp_q.pop_front();
         n_cmp++;
         if (pk !== e.k || pd !== e.d || pv !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_pop%0d got %0d/%0d want %0d/%0d",
                     i, pk, pd, e.k, e.d);
         end
      end
   endtask

   task automatic test_full_empty();
      logic [7:0] pk, pd; logic pv, es; int b;
      logic [7:0] k;
      ent_t e;
      for (int i = 0; i < N; i++) begin
         k = 8'((i * 7) % 16 + 50);
         do_cmd(PUSH, k, k ^ 8'h5a, pk, pd, pv, es, b);
         mdl.push_back('{k: k, d: k ^ 8'h5a});
      end
      n_cmp++;
      if (full !== 1'b1 || count !== 5'd16) begin
         n_bad++;
         $display("FAIL full_set got full=%b cnt=%0d want 1/16", full, count);
      end
      do_cmd(PUSH, 8'd1, 8'd1, pk, pd, pv, es, b);
      n_cmp++;
      if (es !== 1'b1 || count !== 5'd16 || top_key !== 8'd50) begin
         n_bad++;
         $display("FAIL push_full got err=%b cnt=%0d top=%0d want 1/16/50",
                  es, count, top_key);
      end
      @(negedge clock);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_pulse got %b want 0", err);
      end
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(model_take_min());
         do_cmd(POP, 8'd0, 8'd0, pk, pd, pv, es, b);
         e = exp_q.pop_front();
         n_cmp++;
         if (pk !== e.k || pd !== e.d || es !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pop%0d got %0d/%0d want %0d/%0d",
                     i, pk, pd, e.k, e.d);
         end
      end
      do_cmd(POP, 8'd0, 8'd0, pk, pd, pv, es, b);
      n_cmp++;
      if (es !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL pop_empty got err=%b cnt=%0d want 1/0", es, count);
      end
      do_cmd(REPL, 8'd3, 8'd3, pk, pd, pv, es, b);
      n_cmp++;
      if (es !== 1'b1 || count !== 5'd0) begin
         n_bad++;
         $display("FAIL repl_empty got err=%b cnt=%0d want 1/0", es, count);
      end
   endtask

   task automatic test_replace();
      logic [7:0] pk, pd; logic pv, es; int b;
      logic [7:0] ks [3];
      ent_t e;
      ks = '{8'd5, 8'd2, 8'd6};
      foreach (ks[i]) begin
         do_cmd(PUSH, ks[i], ks[i] + 8'd100, pk, pd, pv, es, b);
         mdl.push_back('{k: ks[i], d: ks[i] + 8'd100});
      end
      exp_q.push_back(model_take_min());
      mdl.push_back('{k: 8'd7, d: 8'd107});
      do_cmd(REPL, 8'd7, 8'd107, pk, pd, pv, es, b);
      e = exp_q.pop_front();
      n_cmp++;
      if (pk !== e.k || pd !== e.d || top_key !== 8'd5 ||
          top_data !== 8'd105 || count !== 5'd3) begin
         n_bad++;
         $display("FAIL repl7 got old=%0d top=%0d cnt=%0d want %0d/5/3",
                  pk, top_key, count, e.k);
      end
      exp_q.push_back(model_take_min());
      mdl.push_back('{k: 8'd0, d: 8'd77});
      do_cmd(REPL, 8'd0, 8'd77, pk, pd, pv, es, b);
      e = exp_q.pop_front();
      n_cmp++;
      if (pk !== e.k || top_key !== 8'd0 || top_data !== 8'd77 ||
          b !== 1 || count !== 5'd3) begin
         n_bad++;
         $display("FAIL repl0 got old=%0d top=%0d busy=%0d want %0d/0/1",
                  pk, top_key, b, e.k);
      end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model_take_min());
         do_cmd(POP, 8'd0, 8'd0, pk, pd, pv, es, b);
         e = exp_q.pop_front();
         n_cmp++;
         if (pk !== e.k || pd !== e.d) begin
            n_bad++;
            $display("FAIL repl_drain%0d got %0d/%0d want %0d/%0d",
                     i, pk, pd, e.k, e.d);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pk, pd; logic pv, es; int b;
      int worst = 0;
      ent_t e;
      for (int i = 0; i < N; i++) begin
         do_cmd(PUSH, 8'(15 - i), 8'(i), pk, pd, pv, es, b);
         mdl.push_back('{k: 8'(15 - i), d: 8'(i)});
         if (b > worst) worst = b;
         n_cmp++;
         if (count !== 5'(i + 1) || b > 5) begin
            n_bad++;
            $display("FAIL b2b_push%0d got cnt=%0d busy=%0d want %0d/<=5",
                     i, count, b, i + 1);
         end
      end
      n_cmp++;
      if (worst !== 5) begin
         n_bad++;
         $display("FAIL b2b_worst got %0d want 5", worst);
      end
      check_heap("b2b");
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(model_take_min());
         do_cmd(POP, 8'd0, 8'd0, pk, pd, pv, es, b);
         e = exp_q.pop_front();
         n_cmp++;
         if (pk !== e.k || pd !== e.d || b > 5) begin
            n_bad++;
            $display("FAIL b2b_pop%0d got %0d/%0d busy=%0d want %0d/%0d",
                     i, pk, pd, b, e.k, e.d);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] pk, pd, k, d; logic pv, es, xe; int b;
      logic [1:0] c;
      ent_t e;
      int hit;
      for (int n = 0; n < 10000; n++) begin
         c = 2'($urandom_range(0, 3));
         k = 8'($urandom_range(0, 15));
         d = 8'($urandom_range(0, 255));
         xe = (c == PUSH && mdl.size() == N) ||
              ((c == POP || c == REPL) && mdl.size() == 0);
         if (!xe && (c == POP || c == REPL)) begin
            e = model_take_min();
            mdl.push_back(e);
            exp_q.push_back(e);
         end
         do_cmd(c, k, d, pk, pd, pv, es, b);
         if (!xe && (c == POP || c == REPL)) begin
            e = exp_q.pop_front();
            hit = -1;
            foreach (mdl[i])
               if (hit < 0 && mdl[i].k == e.k && mdl[i].d == pd) hit = i;
            n_cmp++;
            if (pk !== e.k || hit < 0) begin
               n_bad++;
               $display("FAIL rnd_pop%0d got %0d/%0d want key %0d",
                        n, pk, pd, e.k);
            end
            if (hit < 0) begin
               foreach (mdl[i]) if (hit < 0 && mdl[i].k == e.k) hit = i;
            end
            mdl.delete(hit);
         end
         if (!xe && (c == PUSH || c == REPL)) mdl.push_back('{k: k, d: d});
         n_cmp++;
         if (es !== xe || count !== 5'(mdl.size()) || b > 5) begin
            n_bad++;
            $display("FAIL rnd_cmd%0d c=%0d err=%b/%b cnt=%0d/%0d busy=%0d",
                     n, c, es, xe, count, mdl.size(), b);
         end
         check_heap("rnd");
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      test_reset();
      test_basic();
      test_full_empty();
      test_replace();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
